// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth digit decode for the iterative multiplier
package booth_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} mul_state_t;

  function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
    case (triplet)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_decoder.sv
// rtl/booth_decoder.sv - slices the multiplier into overlapping radix-4 Booth triplets
module booth_decoder #(
  parameter int N = 32
) (
  input  logic [N-1:0]       b,
  output logic [N/2*3-1:0]   triplets
);

  // b[-1] is an implicit zero below the LSB.
  logic [N:0] b_pad;
  assign b_pad = {b, 1'b0};

  for (genvar i = 0; i < N/2; i++) begin : g_row
    assign triplets[i*3 +: 3] = b_pad[2*i +: 3];
  end

endmodule

// File: rtl/booth_pp_row.sv
// rtl/booth_pp_row.sv - sums S shifted Booth partial products for one iteration group
import booth_pkg::*;

module booth_pp_row #(
  parameter int N  = 32,
  parameter int S  = 4,
  parameter int CW = 2
) (
  input  logic [S*3-1:0] digits,
  input  logic [2*N-1:0] a_ext,
  input  logic [CW-1:0]  j,
  output logic [2*N-1:0] row_sum
);

  logic [2*N-1:0] pp;
  int             shift;

  always_comb begin
    row_sum = '0;
    pp      = '0;
    shift   = 0;
    for (int r = 0; r < S; r++) begin
      case (booth_digit_t'(digits[r*3 +: 3]))
        POS1:    pp = a_ext;
        POS2:    pp = a_ext << 1;
        NEG1:    pp = -a_ext;
        NEG2:    pp = -(a_ext << 1);
        default: pp = '0;
      endcase
      // Row weight is 4^i, i = j*S + r.
      shift   = 2 * (int'(j) * S + r);
      row_sum = row_sum + (pp << shift);
    end
  end

endmodule

// File: rtl/booth_multiplier_iter.sv
// rtl/booth_multiplier_iter.sv - iterative radix-4 Booth multiplier with valid/ready handshakes
import booth_pkg::*;

module booth_multiplier_iter #(
  parameter int N = 32,
  parameter int S = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  input  logic           i_a_signed,
  input  logic           i_b_signed,
  input  logic           i_kill,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [2*N-1:0] o_result
);

  localparam int M  = N / 2;
  localparam int K  = M / S;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  mul_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] acc_q, a_ext_q, res_q;
  logic [N-1:0]   b_q;
  logic           b_signed_q;

  logic [M*3-1:0] triplets;
  logic [S*3-1:0] group, digits;
  logic [2*N-1:0] row_sum, corr, acc_corr;
  logic           accept, last_iter;

  booth_decoder #(.N(N)) u_dec (
    .b        (b_q),
    .triplets (triplets)
  );

  assign group = triplets[int'(cnt_q)*S*3 +: S*3];

  always_comb begin
    digits = '0;
    for (int r = 0; r < S; r++) begin
      digits[r*3 +: 3] = booth_decode(group[r*3 +: 3]);
    end
  end

  booth_pp_row #(.N(N), .S(S), .CW(CW)) u_row (
    .digits  (digits),
    .a_ext   (a_ext_q),
    .j       (cnt_q),
    .row_sum (row_sum)
  );

  // Recoding reads b as signed; an unsigned b with its MSB set needs +a*2^N back.
  assign corr      = (!b_signed_q && b_q[N-1]) ? (a_ext_q << N) : '0;
  assign acc_corr  = acc_q + corr;

  assign o_ready   = (state_q == IDLE) || (state_q == DONE && i_ready);
  assign o_valid   = (state_q == DONE);
  assign o_result  = res_q;
  assign accept    = i_valid && o_ready && !i_kill;
  assign last_iter = (cnt_q == CW'(K - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ITER;
      ITER:    if (last_iter) state_d = CORR;
      CORR:    state_d = DONE;
      DONE:    if (i_ready) state_d = i_valid ? ITER : IDLE;
      default: state_d = IDLE;
    endcase
    if (i_kill) state_d = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // res_q only loads from the corrected sum, so partial products never reach o_result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      a_ext_q    <= '0;
      b_q        <= '0;
      b_signed_q <= 1'b0;
      res_q      <= '0;
    end else if (accept) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      a_ext_q    <= {{N{i_a_signed & i_a[N-1]}}, i_a};
      b_q        <= i_b;
      b_signed_q <= i_b_signed;
    end else if (!i_kill && state_q == ITER) begin
      acc_q <= acc_q + row_sum;
      cnt_q <= cnt_q + 1'b1;
    end else if (!i_kill && state_q == CORR) begin
      acc_q <= acc_corr;
      res_q <= acc_corr;
    end
  end

endmodule

// File: tb/tb_booth_multiplier_iter.sv
// tb/tb_booth_multiplier_iter.sv - scoreboard bench for booth_multiplier_iter
module tb_booth_multiplier_iter;

  localparam int N = 32;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic           i_valid;
  logic           o_ready;
  logic [N-1:0]   i_a;
  logic [N-1:0]   i_b;
  logic           i_a_signed;
  logic           i_b_signed;
  logic           i_kill;
  logic           o_valid;
  logic           i_ready;
  logic [2*N-1:0] o_result;

  logic [2*N-1:0] sb[$];
  int             n_cmp = 0;
  int             n_err = 0;

  booth_multiplier_iter #(.N(N), .S(4)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_a_signed (i_a_signed),
    .i_b_signed (i_b_signed),
    .i_kill     (i_kill),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic as, input logic bs);
    logic signed [63:0] ea, eb;
    ea = as ? {{32{a[31]}}, a} : {32'b0, a};
    eb = bs ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic as, input logic bs);
    i_valid    = 1'b1;
    i_a        = a;
    i_b        = b;
    i_a_signed = as;
    i_b_signed = bs;
    sb.push_back(model(a, b, as, bs));
    tick();
    i_valid    = 1'b0;
    i_a        = $urandom;
    i_b        = $urandom;
    i_a_signed = 1'($urandom);
    i_b_signed = 1'($urandom);
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (o_valid !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b1;
    i_a = '0; i_b = '0; i_a_signed = 1'b0; i_b_signed = 1'b0;
    #2;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", o_ready); end
    n_cmp++; if (o_result !== 64'h0) begin n_err++; $display("FAIL reset_result got %h want 0", o_result); end
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_signed_latency;
    int e;
    logic [63:0] exp;
    issue(32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1);
    wait_valid(e);
    exp = sb.pop_front();
    n_cmp++; if (e !== 5) begin n_err++; $display("FAIL latency got %0d want 5", e); end
    n_cmp++; if (o_result !== exp) begin n_err++; $display("FAIL signed_result got %h want %h", o_result, exp); end
    tick();
  endtask

  task automatic test_products;
    logic [31:0] ta[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] tb[3] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic        tas[3] = '{1'b0, 1'b1, 1'b1};
    logic        tbs[3] = '{1'b0, 1'b0, 1'b1};
    int e;
    logic [63:0] exp;
    for (int k = 0; k < 3; k++) begin
      issue(ta[k], tb[k], tas[k], tbs[k]);
      wait_valid(e);
      exp = sb.pop_front();
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL prod%0d_valid timeout", k); end
      n_cmp++; if (o_result !== exp) begin n_err++; $display("FAIL prod%0d got %h want %h", k, o_result, exp); end
      tick();
    end
  endtask

  task automatic test_random;
    int e;
    logic [63:0] exp;
    for (int k = 0; k < 8; k++) begin
      issue($urandom, $urandom, 1'($urandom), 1'($urandom));
      wait_valid(e);
      exp = sb.pop_front();
      n_cmp++; if (o_result !== exp || e !== 5) begin
        n_err++; $display("FAIL rand%0d got %h/%0d want %h/5", k, o_result, e, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    int e;
    logic [63:0] exp;
    i_ready = 1'b0;
    issue(32'd5, 32'd7, 1'b0, 1'b0);
    wait_valid(e);
    exp = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (o_result !== exp || o_valid !== 1'b1) begin
        n_err++; $display("FAIL hold%0d got %h/%b want %h/1", k, o_result, o_valid, exp);
      end
      n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d_ready got %b want 0", k, o_ready); end
      tick();
    end
    i_ready = 1'b1; i_valid = 1'b1; i_a = 32'd2; i_b = 32'd3; i_a_signed = 1'b0; i_b_signed = 1'b0;
    sb.push_back(model(32'd2, 32'd3, 1'b0, 1'b0));
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", o_ready); end
    tick();
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_bubble got %b want 0", o_valid); end
    wait_valid(e);
    exp = sb.pop_front();
    n_cmp++; if (o_result !== exp || e !== 5) begin
      n_err++; $display("FAIL b2b_result got %h/%0d want %h/5", o_result, e, exp);
    end
    tick();
  endtask

  task automatic test_kill;
    int e;
    int seen;
    logic [63:0] exp;
    issue(32'd123, 32'd456, 1'b1, 1'b1);
    tick();
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    void'(sb.pop_front());
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_err++; $display("FAIL kill_iter got valid %b ready %b want 0/1", o_valid, o_ready);
    end
    seen = 0;
    repeat (10) begin tick(); if (o_valid === 1'b1) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL kill_iter_novalid got %0d want 0", seen); end

    i_ready = 1'b0;
    issue(32'd9, 32'd9, 1'b0, 1'b0);
    wait_valid(e);
    exp = sb.pop_front();
    n_cmp++; if (o_result !== exp) begin n_err++; $display("FAIL kill_pre got %h want %h", o_result, exp); end
    i_kill = 1'b1; i_valid = 1'b1; i_ready = 1'b1; i_a = 32'd77; i_b = 32'd77;
    tick();
    i_kill = 1'b0; i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_err++; $display("FAIL kill_done got valid %b ready %b want 0/1", o_valid, o_ready);
    end
    n_cmp++; if (o_result !== exp) begin n_err++; $display("FAIL kill_keep got %h want %h", o_result, exp); end
    seen = 0;
    repeat (10) begin tick(); if (o_valid === 1'b1) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL kill_drop got %0d want 0", seen); end
  endtask

  task automatic test_reset_mid;
    int e;
    logic [63:0] exp;
    issue(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0);
    tick();
    #3;
    i_rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid got valid %b ready %b want 0/1", o_valid, o_ready);
    end
    n_cmp++; if (o_result !== 64'h0) begin n_err++; $display("FAIL rst_mid_result got %h want 0", o_result); end
    #2;
    i_rst_n = 1'b1;
    tick();
    issue(32'h89ABCDEF, 32'hFEDCBA98, 1'b1, 1'b1);
    wait_valid(e);
    exp = sb.pop_front();
    n_cmp++; if (o_result !== exp || e !== 5) begin
      n_err++; $display("FAIL rst_after got %h/%0d want %h/5", o_result, e, exp);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_signed_latency();
    test_products();
    test_random();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
